// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with saturating direction counters
module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       lookup_pc,
  output logic              predict_hit,
  output logic              predict_taken,
  output logic [31:0]       predict_npc,
  input  logic              update_en,
  input  logic [31:0]       update_pc,
  input  logic              update_taken,
  input  logic [31:0]       update_target,
  input  logic              update_mispredict,
  input  logic              flush_all,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_WEAK_T = CNT_W'(1 << (CNT_W - 1));
  localparam logic [STAT_W-1:0] STAT_MAX   = '1;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [CNT_W-1:0]   cnt_mem    [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [CNT_W-1:0] u_cnt;
  logic [CNT_W-1:0] cnt_next;

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[31:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[31:IDX_W+2];

  // Lookup reads the arrays directly; no bypass of an update in flight
  assign predict_hit   = valid[l_idx] && (tag_mem[l_idx] == l_tag);
  assign predict_taken = predict_hit && cnt_mem[l_idx][CNT_W-1];
  assign predict_npc   = predict_taken ? target_mem[l_idx] : lookup_pc + 32'd4;

  assign u_hit = valid[u_idx] && (tag_mem[u_idx] == u_tag);
  assign u_cnt = cnt_mem[u_idx];

  // Saturating step of the resolved entry's direction counter
  always_comb begin
    cnt_next = u_cnt;
    if (update_taken) begin
      if (u_cnt != CNT_MAX) cnt_next = u_cnt + CNT_W'(1);
    end else begin
      if (u_cnt != '0) cnt_next = u_cnt - CNT_W'(1);
    end
  end

  // Entry training and allocation; flush wins over a same-cycle update
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        cnt_mem[i]    <= '0;
      end
    end else if (flush_all) begin
      valid <= '0;
    end else if (update_en) begin
      if (u_hit) begin
        cnt_mem[u_idx] <= cnt_next;
        if (update_taken) target_mem[u_idx] <= update_target;
      end else if (update_taken) begin
        valid[u_idx]      <= 1'b1;
        tag_mem[u_idx]    <= u_tag;
        target_mem[u_idx] <= update_target;
        cnt_mem[u_idx]    <= CNT_WEAK_T;
      end
    end
  end

  // Mispredict statistic, saturating at all-ones and independent of flush
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mispredict_count <= '0;
    end else if (update_en && update_mispredict && (mispredict_count != STAT_MAX)) begin
      mispredict_count <= mispredict_count + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - bench for branch_target_predictor
module tb_branch_target_predictor;

  localparam int ENTRIES  = 16;
  localparam int CNT_W    = 2;
  localparam int STAT_W   = 2;
  localparam int CNT_TOP  = (1 << CNT_W) - 1;
  localparam int CNT_HALF = 1 << (CNT_W - 1);
  localparam int STAT_TOP = (1 << STAT_W) - 1;

  logic              CLK;
  logic              nRST;
  logic [31:0]       lookup_pc;
  logic              predict_hit;
  logic              predict_taken;
  logic [31:0]       predict_npc;
  logic              update_en;
  logic [31:0]       update_pc;
  logic              update_taken;
  logic [31:0]       update_target;
  logic              update_mispredict;
  logic              flush_all;
  logic [STAT_W-1:0] mispredict_count;

  branch_target_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc),
    .predict_hit(predict_hit), .predict_taken(predict_taken), .predict_npc(predict_npc),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict),
    .flush_all(flush_all), .mispredict_count(mispredict_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model: each slot remembers the full PC of the branch that owns it
  bit        m_valid  [ENTRIES];
  bit [31:0] m_owner  [ENTRIES];
  bit [31:0] m_target [ENTRIES];
  int        m_cnt    [ENTRIES];
  int        m_count = 0;

  function automatic int slot_of(input bit [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit same_line(input bit [31:0] a, input bit [31:0] b);
    return (a / (4 * ENTRIES)) == (b / (4 * ENTRIES));
  endfunction

  function automatic bit exp_hit(input bit [31:0] pc);
    return m_valid[slot_of(pc)] && same_line(m_owner[slot_of(pc)], pc);
  endfunction

  function automatic bit exp_taken(input bit [31:0] pc);
    return exp_hit(pc) && (m_cnt[slot_of(pc)] >= CNT_HALF);
  endfunction

  function automatic bit [31:0] exp_npc(input bit [31:0] pc);
    return exp_taken(pc) ? m_target[slot_of(pc)] : pc + 32'd4;
  endfunction

  // Model state advance on the clock, cleared by the asynchronous reset
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0; m_owner[i] = '0; m_target[i] = '0; m_cnt[i] = 0;
      end
      m_count = 0;
    end else begin
      if (update_en && update_mispredict && m_count < STAT_TOP) m_count = m_count + 1;
      if (flush_all) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (update_en) begin
        int s;
        s = slot_of(update_pc);
        if (exp_hit(update_pc)) begin
          if (update_taken) begin
            m_cnt[s] = (m_cnt[s] < CNT_TOP) ? m_cnt[s] + 1 : CNT_TOP;
            m_target[s] = update_target;
          end else begin
            m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
          end
        end else if (update_taken) begin
          m_valid[s] = 1'b1; m_owner[s] = update_pc; m_target[s] = update_target; m_cnt[s] = CNT_HALF;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, mid-period, the outputs must match the model
  always @(negedge CLK) begin
    check("cmp_hit", {31'd0, predict_hit}, {31'd0, exp_hit(lookup_pc)});
    check("cmp_taken", {31'd0, predict_taken}, {31'd0, exp_taken(lookup_pc)});
    check("cmp_npc", predict_npc, exp_npc(lookup_pc));
    check("cmp_count", {30'd0, mispredict_count}, m_count);
  end

  task automatic step(input logic [31:0] lpc, input bit uen, input logic [31:0] upc,
                      input bit utk, input logic [31:0] utgt, input bit umis, input bit fl);
    @(posedge CLK);
    #1;
    lookup_pc = lpc; update_en = uen; update_pc = upc; update_taken = utk;
    update_target = utgt; update_mispredict = umis; flush_all = fl;
    #1;
  endtask

  task automatic look(input logic [31:0] lpc);
    step(lpc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] lpc, input logic [31:0] upc, input bit tk, input logic [31:0] tgt);
    step(lpc, 1'b1, upc, tk, tgt, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string name, input bit h, input bit t, input logic [31:0] npc);
    check({name, "_hit"}, {31'd0, predict_hit}, {31'd0, h});
    check({name, "_taken"}, {31'd0, predict_taken}, {31'd0, t});
    check({name, "_npc"}, predict_npc, npc);
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 3) == 0) pc = pc | 32'hFFFF_F000;
    return pc;
  endfunction

  initial begin
    nRST = 1'b0;
    lookup_pc = 32'h40; update_en = 0; update_pc = 0; update_taken = 0;
    update_target = 0; update_mispredict = 0; flush_all = 0;
    #2;
    expect_out("reset", 1'b0, 1'b0, 32'h44);
    check("reset_count", {30'd0, mispredict_count}, 32'd0);
    #10 nRST = 1'b1;

    upd(32'h40, 32'h40, 1'b1, 32'h100);
    expect_out("alloc_same_cycle", 1'b0, 1'b0, 32'h44);
    look(32'h40);
    expect_out("alloc_next", 1'b1, 1'b1, 32'h100);
    upd(32'h40, 32'h40, 1'b1, 32'h100);
    upd(32'h40, 32'h40, 1'b1, 32'h100);
    upd(32'h40, 32'h40, 1'b0, 32'h0);
    expect_out("st_sat", 1'b1, 1'b1, 32'h100);
    upd(32'h40, 32'h40, 1'b0, 32'h0);
    expect_out("wt", 1'b1, 1'b1, 32'h100);
    look(32'h40);
    expect_out("wnt", 1'b1, 1'b0, 32'h44);
    upd(32'h40, 32'h40, 1'b0, 32'h0);
    upd(32'h40, 32'h40, 1'b0, 32'h0);
    upd(32'h40, 32'h40, 1'b1, 32'h100);
    look(32'h40);
    expect_out("snt_held", 1'b1, 1'b0, 32'h44);
    upd(32'h40, 32'h40, 1'b1, 32'h180);
    look(32'h40);
    expect_out("target_ovw", 1'b1, 1'b1, 32'h180);

    upd(32'h40, 32'h440, 1'b1, 32'h800);
    look(32'h40);
    expect_out("alias_evict", 1'b0, 1'b0, 32'h44);
    look(32'h440);
    expect_out("alias_new", 1'b1, 1'b1, 32'h800);
    upd(32'h440, 32'h840, 1'b0, 32'h0);
    look(32'h440);
    expect_out("alias_nt_miss", 1'b1, 1'b1, 32'h800);

    upd(32'h80, 32'h80, 1'b1, 32'h200);
    expect_out("same_idx_pre", 1'b0, 1'b0, 32'h84);
    look(32'h80);
    expect_out("same_idx_post", 1'b1, 1'b1, 32'h200);

    step(32'h80, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 1'b1);
    look(32'h40);
    expect_out("flush_40", 1'b0, 1'b0, 32'h44);
    look(32'h80);
    expect_out("flush_80", 1'b0, 1'b0, 32'h84);
    look(32'hFFFF_FFFC);
    expect_out("npc_wrap", 1'b0, 1'b0, 32'h0);

    step(32'h0, 1'b0, 32'h1000, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(32'h0, 1'b1, 32'h1000, 1'b0, 32'h0, i < 4, 1'b0);
      check("mis_count", {30'd0, mispredict_count}, (i < STAT_TOP) ? i : STAT_TOP);
    end

    upd(32'h40, 32'h40, 1'b1, 32'h100);
    look(32'h40);
    expect_out("pre_reset", 1'b1, 1'b1, 32'h100);
    upd(32'h40, 32'hC0, 1'b1, 32'h500);
    #1 nRST = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, 32'h44);
    check("async_reset_count", {30'd0, mispredict_count}, 32'd0);
    update_en = 1'b0;
    @(posedge CLK);
    #3 nRST = 1'b1;
    look(32'hC0);
    expect_out("reset_abort", 1'b0, 1'b0, 32'hC4);

    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK);
      #1;
      nRST = ($urandom_range(0, 299) != 0);
      lookup_pc = rnd_pc();
      update_en = $urandom_range(0, 1);
      update_pc = rnd_pc() | 32'($urandom_range(0, 3));
      update_taken = $urandom_range(0, 2) != 0;
      update_target = $urandom;
      update_mispredict = $urandom_range(0, 3) == 0;
      flush_all = $urandom_range(0, 31) == 0;
    end
    @(posedge CLK);
    #1 nRST = 1'b1;
    update_en = 1'b0;
    flush_all = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
